// File: rtl/mig2stream.sv
// mig2stream: plays frames already committed to DRAM back through one MIG read port as a
// 16-bit dtype-framed stream. Define MIG2STREAM_HEADER_EN to also read and emit the header region.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 4'd1
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 4'd2
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END 4'd3
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'd4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'd5
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'd6
`endif

module mig2stream #(
  parameter int ADDR_WIDTH   = 30,
  parameter int HEADER_BYTES = 128,
  parameter int RFIFO_DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic                    frame_valid,
  input  logic [ADDR_WIDTH-1:0]   frame_addr,
  input  logic [29:0]             frame_len,
  output logic                    frame_ack,
  input  logic                    stall,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]             datao,
  output logic                    pR_cmd_en,
  output logic [2:0]              pR_cmd_instr,
  output logic [5:0]              pR_cmd_bl,
  output logic [ADDR_WIDTH-1:0]   pR_cmd_byte_addr,
  input  logic                    pR_cmd_full,
  output logic                    pR_rd_en,
  input  logic [31:0]             pR_rd_data,
  input  logic                    pR_rd_empty,
  output logic                    busy
);
  localparam int CW = $clog2(RFIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CREDIT_LIMIT = CW'(RFIFO_DEPTH - 16);
  localparam logic [28:0]   HDR_BEATS    = 29'(HEADER_BYTES / 2);
  localparam logic [29:0]   HDR_LEN      = 30'(HEADER_BYTES);

  typedef enum logic [2:0] {IDLE, HSTART, HEADER, HEND, FSTART, PIXELS, FEND} state_t;

  state_t                  state_q, state_d;
  logic [29:0]             len_q, len_d;
  logic [28:0]             beats_q, beats_d;
  logic                    half_q, half_d;
  logic [23:0]             bursts_q, bursts_d;
  logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic                    cmd_en_q, cmd_en_d;
  logic                    rd_en_q, rd_en_d;
  logic [CW-1:0]           credits_q, credits_d;
  logic                    dvo_q, dvo_d;
  logic                    ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic [`DTYPE_WIDTH-1:0] dtype_q, dtype_d;
  logic [15:0]             data_q, data_d;
  logic                    data_ok, cmd_ok;

  // The FIFO head is stale while a registered pop is pending, so a data beat also waits out rd_en_q.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beats_d     = beats_q;
    half_d      = half_q;
    bursts_d    = bursts_q;
    next_addr_d = next_addr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_en_d    = 1'b0;
    rd_en_d     = 1'b0;
    dvo_d       = 1'b0;
    ack_d       = 1'b0;
    busy_d      = busy_q;
    dtype_d     = dtype_q;
    data_d      = data_q;
    data_ok     = !pR_rd_empty && !stall && !rd_en_q;
    cmd_ok      = !pR_cmd_full && !cmd_en_q && (credits_q <= CREDIT_LIMIT) && (bursts_q != '0);
    credits_d   = credits_q + (cmd_en_q ? CW'(16) : '0) - (rd_en_q ? CW'(1) : '0);

    if (!enable) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      bursts_d = '0;
      half_d   = 1'b0;
      rd_en_d  = !pR_rd_empty && !rd_en_q;
    end else begin
      if (cmd_ok) begin
        cmd_en_d    = 1'b1;
        cmd_addr_d  = next_addr_q;
        next_addr_d = next_addr_q + ADDR_WIDTH'(64);
        bursts_d    = bursts_q - 24'd1;
      end
      case (state_q)
        IDLE: begin
          rd_en_d = !pR_rd_empty && !rd_en_q;
          // Waiting for zero credits keeps data still in flight from an aborted frame out of the next one.
          if (frame_valid && credits_q == '0) begin
            len_d  = frame_len;
            busy_d = 1'b1;
            half_d = 1'b0;
`ifdef MIG2STREAM_HEADER_EN
            state_d     = HSTART;
            next_addr_d = frame_addr;
            bursts_d    = frame_len[29:6];
`else
            state_d     = FSTART;
            next_addr_d = frame_addr + ADDR_WIDTH'(HEADER_BYTES);
            bursts_d    = 24'((frame_len - HDR_LEN) >> 6);
`endif
          end
        end
        HSTART: if (!stall) begin
          dvo_d   = 1'b1;
          dtype_d = `DTYPE_HEADER_START;
          data_d  = '0;
          beats_d = HDR_BEATS;
          state_d = HEADER;
        end
        HEADER, PIXELS: if (data_ok) begin
          dvo_d   = 1'b1;
          dtype_d = (state_q == HEADER) ? `DTYPE_HEADER : `DTYPE_PIXEL;
          data_d  = half_q ? pR_rd_data[31:16] : pR_rd_data[15:0];
          rd_en_d = half_q;
          half_d  = !half_q;
          beats_d = beats_q - 29'd1;
          if (beats_q == 29'd1) state_d = (state_q == HEADER) ? HEND : FEND;
        end
        HEND: if (!stall) begin
          dvo_d   = 1'b1;
          dtype_d = `DTYPE_HEADER_END;
          data_d  = '0;
          state_d = FSTART;
        end
        FSTART: if (!stall) begin
          dvo_d   = 1'b1;
          dtype_d = `DTYPE_FRAME_START;
          data_d  = '0;
          beats_d = 29'((len_q - HDR_LEN) >> 1);
          state_d = PIXELS;
        end
        FEND: if (!stall) begin
          dvo_d   = 1'b1;
          dtype_d = `DTYPE_FRAME_END;
          data_d  = '0;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      len_q       <= '0;
      beats_q     <= '0;
      half_q      <= 1'b0;
      bursts_q    <= '0;
      next_addr_q <= '0;
      cmd_addr_q  <= '0;
      cmd_en_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      credits_q   <= '0;
      dvo_q       <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      dtype_q     <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beats_q     <= beats_d;
      half_q      <= half_d;
      bursts_q    <= bursts_d;
      next_addr_q <= next_addr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_en_q    <= cmd_en_d;
      rd_en_q     <= rd_en_d;
      credits_q   <= credits_d;
      dvo_q       <= dvo_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      dtype_q     <= dtype_d;
      data_q      <= data_d;
    end
  end

  assign pR_cmd_instr     = 3'd1;
  assign pR_cmd_bl        = 6'd15;
  assign pR_cmd_en        = cmd_en_q;
  assign pR_cmd_byte_addr = cmd_addr_q;
  assign pR_rd_en         = rd_en_q;
  assign dvo              = dvo_q;
  assign dtypeo           = dtype_q;
  assign datao            = data_q;
  assign frame_ack        = ack_q;
  assign busy             = busy_q;

endmodule
